clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the divisor and counter.
REQ-002 SHALL have parameter DIV_DEFAULT, default 90: half-period terminal count after reset (66 kHz-class from 12 MHz).
REQ-003 SHALL have parameter IDLE_LVL, default 1'b0: CLKOUT level at reset, when disabled, and on SYNC.
REQ-004 SHALL have ports in this order:
- CLK  in  1  system clock (12 MHz).
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  count enable.
- SYNC  in  1  phase restart pulse.
- DIV_IN  in  CNT_W  new half-period terminal count.
- DIV_LD  in  1  load strobe for DIV_IN.
- DIV_ACK  out  1  one-cycle pulse: new divisor is in effect.
- CLKOUT  out  1  divided clock.
- RISE  out  1  one-cycle strobe: CLKOUT has toggled to 1.
- FALL  out  1  one-cycle strobe: CLKOUT has toggled to 0.
REQ-005 SHALL use one clock, CLK. RST is asynchronous and active-high. All other inputs are sampled on the CLK rising edge.

Function
REQ-006 SHALL keep these registers: cnt (CNT_W bits), div_act (active terminal count), div_sh (shadow), pend (load pending), CLKOUT.
REQ-007 SHALL apply the following per edge when EN=1 and SYNC=0:
- cnt==div_act: CLKOUT inverts and cnt<=0.
- otherwise: cnt<=cnt+1.
- Resulting period is 2*(div_act+1) CLK cycles at 50% duty.
REQ-008 SHALL give the first toggle after enable or SYNC on the (div_act+1)-th counting edge.
REQ-009 SHALL accept DIV_IN==0 and produce CLKOUT = CLK/2. Counter arithmetic SHALL be unsigned with no wrap beyond div_act.
REQ-010 SHALL, on DIV_LD=1, capture DIV_IN into div_sh and set pend. A DIV_LD while pend=1 overwrites div_sh; exactly one DIV_ACK results.
REQ-011 SHALL define the period boundary as a toggle back to IDLE_LVL. Pending divisors transfer only there, or on the conditions in REQ-012.
- On that edge: div_act<=div_sh, pend<=0.
- The current period always completes at the old divisor.
REQ-012 SHALL also transfer a pending divisor on any edge where EN=0 or SYNC=1.
REQ-013 SHALL assert DIV_ACK for exactly one cycle, registered on the edge that transfers div_sh.
REQ-014 SHALL, when DIV_LD coincides with a transfer edge, transfer the old div_sh and ACK it. The new value stays pending.
REQ-015 SHALL, on an edge with EN=0, set cnt<=0 and CLKOUT<=IDLE_LVL, with no RISE/FALL strobe.
REQ-016 SHALL, on an edge with SYNC=1, set cnt<=0 and CLKOUT<=IDLE_LVL regardless of EN. SYNC has priority over counting.
REQ-017 SHALL register RISE/FALL so they are high in the same cycle that CLKOUT first shows the new level. They fire only from REQ-007 counting toggles, never from forced idle transitions.

Reset
REQ-018 SHALL, while RST=1, asynchronously force:
- CLKOUT=IDLE_LVL.
- cnt=0, div_act=DIV_DEFAULT, div_sh=DIV_DEFAULT, pend=0.
- DIV_ACK=0, RISE=0, FALL=0.
REQ-019 SHALL discard a load pending at reset with no DIV_ACK. Counting resumes on the first edge after RST deasserts, if EN=1.

Configuration
REQ-020 SHALL use macro CLKDIV_EDGE_STROBE_EN.
- Defined: RISE/FALL behave per REQ-017.
- Undefined: RISE/FALL are constant 0, with no strobe logic. Port list is unchanged.

Verification
REQ-021 Reset defaults, EN=1 -> CLKOUT first rises at the 91st edge; period 182 cycles; RISE/FALL one cycle each per period.
REQ-022 DIV_IN=3 with DIV_LD during the high phase -> current period finishes at 182; DIV_ACK one cycle at the falling boundary; following periods are 8 cycles.
REQ-023 DIV_IN=0 loaded with EN=0 -> DIV_ACK on the next edge; after EN=1, CLKOUT toggles every edge (period 2).
REQ-024 EN dropped mid-high phase -> CLKOUT=0 next edge, no FALL; re-enable -> first rise after div_act+1 edges. SYNC pulse mid-count -> the same phase restart.
REQ-025 RST asserted asynchronously mid-high with a pending load -> CLKOUT=0 immediately; div_act=90 after release; no DIV_ACK.
REQ-026 Build without CLKDIV_EDGE_STROBE_EN -> REQ-021 stimulus gives RISE=FALL=0 throughout; CLKOUT is unchanged.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50% duty clock divider with a shadowed divisor that reloads only at period boundaries.
// Define CLKDIV_EDGE_STROBE_EN to build the RISE/FALL strobes; otherwise they are tied to 0.
module clk_div_prog #(
   parameter int CNT_W = 16,
   parameter int unsigned DIV_DEFAULT = 90,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             SYNC,
   input  logic [CNT_W-1:0] DIV_IN,
   input  logic             DIV_LD,
   output logic             DIV_ACK,
   output logic             CLKOUT,
   output logic             RISE,
   output logic             FALL
);
   logic [CNT_W-1:0] cnt, div_act, div_sh;
   logic pend, run, hit, xfer;
   assign run = EN & ~SYNC;
   assign hit = cnt == div_act;
   // a held-off or restarted divider is a safe place to swap divisors; otherwise wait for the toggle back to idle
   assign xfer = pend & (~run | (hit & (CLKOUT != IDLE_LVL)));
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         div_act <= CNT_W'(DIV_DEFAULT);
         div_sh  <= CNT_W'(DIV_DEFAULT);
         pend    <= 1'b0;
         CLKOUT  <= IDLE_LVL;
         DIV_ACK <= 1'b0;
      end else begin
         cnt     <= (!run || hit) ? '0 : cnt + 1'b1;
         CLKOUT  <= !run ? IDLE_LVL : (hit ? ~CLKOUT : CLKOUT);
         div_act <= xfer ? div_sh : div_act;
         div_sh  <= DIV_LD ? DIV_IN : div_sh;
         pend    <= DIV_LD | (pend & ~xfer);
         DIV_ACK <= xfer;
      end
   end
`ifdef CLKDIV_EDGE_STROBE_EN
   logic toggle;
   assign toggle = run & hit;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RISE <= 1'b0;
         FALL <= 1'b0;
      end else begin
         RISE <= toggle & ~CLKOUT;
         FALL <= toggle & CLKOUT;
      end
   end
`else
   assign RISE = 1'b0;
   assign FALL = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized and directed checks of clk_div_prog against an edge-counting reference model.
module tb_clk_div_prog;
   localparam int W = 16;
`ifdef CLKDIV_EDGE_STROBE_EN
   localparam bit STB = 1'b1;
`else
   localparam bit STB = 1'b0;
`endif
   logic CLK = 1'b0, RST = 1'b1, EN = 1'b0, SYNC = 1'b0, DIV_LD = 1'b0;
   logic [W-1:0] DIV_IN = '0;
   logic DIV_ACK, CLKOUT, RISE, FALL;
   clk_div_prog dut (
      .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .DIV_IN(DIV_IN), .DIV_LD(DIV_LD),
      .DIV_ACK(DIV_ACK), .CLKOUT(CLKOUT), .RISE(RISE), .FALL(FALL)
   );
   always #5 CLK = ~CLK;
   int tests = 0, fails = 0, cyc = 0, base = 0, ack_cyc = -1;
   int rises[$];
   logic prev_out = 1'b0;
   // model: edges counted since last toggle/restart; a toggle is due after div+1 of them
   int m_run, m_act, m_sh;
   bit m_pend, m_lvl, m_rise, m_fall, m_ack;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask
   function automatic int rise_at(int i);
      return (i < rises.size()) ? rises[i] : -1;
   endfunction
   task automatic model_reset();
      m_run = 0; m_act = 90; m_sh = 90; m_pend = 0; m_lvl = 0;
      m_rise = 0; m_fall = 0; m_ack = 0;
   endtask
   task automatic step(bit en, bit sy, bit ld, int din);
      EN = en; SYNC = sy; DIV_LD = ld; DIV_IN = din[W-1:0];
      @(posedge CLK);
      m_rise = 0; m_fall = 0; m_ack = 0;
      if (!en || sy) begin
         m_run = 0; m_lvl = 0;
         if (m_pend) begin m_act = m_sh; m_pend = 0; m_ack = 1; end
      end else begin
         m_run++;
         if (m_run == m_act + 1) begin
            m_run = 0; m_lvl = !m_lvl; m_rise = m_lvl; m_fall = !m_lvl;
            if (!m_lvl && m_pend) begin m_act = m_sh; m_pend = 0; m_ack = 1; end
         end
      end
      if (ld) begin m_sh = din; m_pend = 1; end
      #1;
      cyc++;
      chk("clkout", CLKOUT, m_lvl);
      chk("div_ack", DIV_ACK, m_ack);
      chk("rise", RISE, STB & m_rise);
      chk("fall", FALL, STB & m_fall);
      if (CLKOUT && !prev_out) rises.push_back(cyc);
      prev_out = CLKOUT;
      if (DIV_ACK) ack_cyc = cyc;
   endtask
   initial begin
      model_reset();
      #3;
      chk("rst_clkout", CLKOUT, 0);
      chk("rst_ack", DIV_ACK, 0);
      chk("rst_rise", RISE, 0);
      chk("rst_fall", FALL, 0);
      @(posedge CLK);
      #2 RST = 1'b0;
      // default divisor, then a reload of 3 during the second high phase
      repeat (280) step(1, 0, 0, 0);
      step(1, 0, 1, 3);
      repeat (120) step(1, 0, 0, 0);
      chk("first_rise", rise_at(0), 91);
      chk("period_182", rise_at(1) - rise_at(0), 182);
      chk("ack_at_fall", ack_cyc, 364);
      chk("rise_after_reload", rise_at(2), 368);
      chk("period_8", rise_at(3) - rise_at(2), 8);
      // divisor 0 loaded while disabled
      step(0, 0, 1, 0);
      chk("hold_low", CLKOUT, 0);
      step(0, 0, 0, 0);
      chk("ack_disabled", ack_cyc, 403);
      rises.delete();
      repeat (10) step(1, 0, 0, 0);
      chk("div0_first", rise_at(0), 404);
      chk("div0_period", rise_at(1) - rise_at(0), 2);
      // divisor 5, EN dropped while high, then SYNC restart
      step(0, 0, 1, 5);
      step(0, 0, 0, 0);
      repeat (7) step(1, 0, 0, 0);
      chk("high_before_drop", CLKOUT, 1);
      step(0, 0, 0, 0);
      chk("drop_low", CLKOUT, 0);
      chk("drop_nofall", FALL, 0);
      rises.delete();
      base = cyc;
      repeat (8) step(1, 0, 0, 0);
      chk("reenable_rise", rise_at(0), base + 6);
      step(1, 1, 0, 0);
      chk("sync_low", CLKOUT, 0);
      chk("sync_nofall", FALL, 0);
      rises.delete();
      base = cyc;
      repeat (8) step(1, 0, 0, 0);
      chk("sync_rise", rise_at(0), base + 6);
      // random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 29) == 0, int'($urandom_range(0, 6)));
      // async reset while high with a load pending
      step(0, 0, 1, 2);
      step(0, 0, 0, 0);
      for (int i = 0; i < 20 && !CLKOUT; i++) step(1, 0, 0, 0);
      chk("high_before_rst", CLKOUT, 1);
      step(1, 0, 1, 7);
      #2 RST = 1'b1;
      #1;
      chk("async_clkout", CLKOUT, 0);
      chk("async_ack", DIV_ACK, 0);
      model_reset();
      #2 RST = 1'b0;
      prev_out = 1'b0;
      rises.delete();
      ack_cyc = -1;
      base = cyc;
      repeat (95) step(1, 0, 0, 0);
      chk("post_rst_rise", rise_at(0), base + 91);
      chk("post_rst_noack", ack_cyc, -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
